// File: rtl/branch_history_table_pkg.sv
// Shared BHT types and default sizes.
// The optional BHT_PC_CHECK_EN build stores the PC index in every snapshot.
package branch_history_table_pkg;
  localparam int XLEN        = 32;
  localparam int BHT_ENTRIES = 256;
  localparam int BHT_IDX_W   = $clog2(BHT_ENTRIES);
  localparam int HIST_W      = 4;
  localparam int SNAP_DEPTH  = 8;

  typedef struct packed {
    logic [BHT_IDX_W-1:0] idx;
    logic [HIST_W-1:0]    hist;
  } bht_snap_t;
endpackage

// File: rtl/branch_history_table_snap_fifo.sv
// Circular in-order snapshot FIFO with a flush that empties it in one cycle.
// Push is ignored when the FIFO is full and pop is ignored when it is empty.
module bht_snap_fifo #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic              i_flush,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_full,
  output logic              o_empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_head, r_tail;
  logic [CNT_W-1:0]  r_count;
  logic              w_push_ok, w_pop_ok;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;
  assign o_rdata   = r_mem[r_head];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_tail <= r_tail + PTR_W'(1);
      if (w_pop_ok)  r_head <= r_head + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop_ok);
    end
  end

  // Storage is not reset; the empty flag masks stale contents.
  always_ff @(posedge i_clk) begin
    if (w_push_ok && !i_flush) r_mem[r_tail] <= i_wdata;
  end
endmodule

// File: rtl/branch_history_table.sv
// Per-PC local branch history table with fetch-time snapshot FIFO for PHT update.
// Define BHT_PC_CHECK_EN to verify retire PC against the stored snapshot index.
module branch_history_table
  import branch_history_table_pkg::*;
#(
  parameter int BHT_ENTRIES_P = BHT_ENTRIES,
  parameter int HIST_W_P      = HIST_W,
  parameter int SNAP_DEPTH_P  = SNAP_DEPTH
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_if_valid,
  input  logic                i_if_is_branch,
  input  logic [XLEN-1:0]     i_if_pc,
  output logic [HIST_W_P-1:0] o_bht_if_out,
  output logic                o_snap_full,
  input  logic                i_rt_valid,
  input  logic [XLEN-1:0]     i_rt_pc,
  input  logic                i_rt_taken,
  input  logic                i_squash,
  output logic [HIST_W_P-1:0] o_bht_ex_out,
  output logic                o_pht_wr_en,
  output logic                o_bht_mismatch
);
  localparam int IDX_W = $clog2(BHT_ENTRIES_P);

  logic [HIST_W_P-1:0] r_tbl [BHT_ENTRIES_P];
  logic [IDX_W-1:0]    w_if_idx, w_rt_idx;
  logic [HIST_W_P-1:0] w_rt_new, w_head_hist;
  logic                w_push, w_pop, w_full, w_empty, w_mm, w_tbl_upd;
  logic                w_unused_pc;

  assign w_if_idx    = i_if_pc[2 +: IDX_W];
  assign w_rt_idx    = i_rt_pc[2 +: IDX_W];
  assign w_unused_pc = ^{i_if_pc[XLEN-1:IDX_W+2], i_if_pc[1:0],
                         i_rt_pc[XLEN-1:IDX_W+2], i_rt_pc[1:0]};

  assign w_rt_new  = {r_tbl[w_rt_idx][HIST_W_P-2:0], i_rt_taken};
  assign w_tbl_upd = i_rt_valid && !w_mm;
  assign w_push    = i_if_valid && i_if_is_branch && !w_full && !i_squash;
  assign w_pop     = i_rt_valid && !w_empty;

  // Same-cycle retire to the fetched entry forwards the post-shift history.
  assign o_bht_if_out = (w_tbl_upd && (w_rt_idx == w_if_idx)) ? w_rt_new : r_tbl[w_if_idx];

`ifdef BHT_PC_CHECK_EN
  localparam int SNAP_W = $bits(bht_snap_t);
  bht_snap_t w_snap_in, w_snap_out;
  assign w_snap_in.idx  = w_if_idx;
  assign w_snap_in.hist = o_bht_if_out;
  assign w_head_hist    = w_snap_out.hist;
  assign w_mm           = w_pop && (w_snap_out.idx != w_rt_idx);
`else
  localparam int SNAP_W = HIST_W_P;
  logic [SNAP_W-1:0] w_snap_in, w_snap_out;
  assign w_snap_in   = o_bht_if_out;
  assign w_head_hist = w_snap_out;
  assign w_mm        = 1'b0;
`endif

  bht_snap_fifo #(
    .DATA_W (SNAP_W),
    .DEPTH  (SNAP_DEPTH_P)
  ) u_snap_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (i_squash),
    .i_wdata (w_snap_in),
    .o_rdata (w_snap_out),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign o_snap_full    = w_full;
  assign o_bht_ex_out   = w_empty ? '0 : w_head_hist;
  assign o_pht_wr_en    = w_pop && !w_mm;
  assign o_bht_mismatch = w_mm;

  // Committed history; squash never touches it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < BHT_ENTRIES_P; i++) r_tbl[i] <= '0;
    end else if (w_tbl_upd) begin
      r_tbl[w_rt_idx] <= w_rt_new;
    end
  end
endmodule

// File: tb/tb_branch_history_table.sv
// Randomized and directed bench for branch_history_table against an array/queue model.
// Honours BHT_PC_CHECK_EN the same way as the design.
module tb_branch_history_table;
  import branch_history_table_pkg::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        if_valid, if_br, rt_valid, rt_taken, squash;
  logic [31:0] if_pc, rt_pc;
  logic [3:0]  bht_if_out, bht_ex_out;
  logic        snap_full, pht_wr_en, bht_mismatch;

  always #5 clk = ~clk;

  branch_history_table dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_if_valid     (if_valid),
    .i_if_is_branch (if_br),
    .i_if_pc        (if_pc),
    .o_bht_if_out   (bht_if_out),
    .o_snap_full    (snap_full),
    .i_rt_valid     (rt_valid),
    .i_rt_pc        (rt_pc),
    .i_rt_taken     (rt_taken),
    .i_squash       (squash),
    .o_bht_ex_out   (bht_ex_out),
    .o_pht_wr_en    (pht_wr_en),
    .o_bht_mismatch (bht_mismatch)
  );

  typedef struct { int idx; int hist; } snap_t;
  int    mtbl [256];
  snap_t mq [$];
  int    checks = 0, errors = 0;

  logic [3:0] exp_if, exp_ex, got_if, got_ex;
  logic       exp_full, exp_wr, exp_mm, got_full, got_wr, got_mm;
  logic       m_pop, m_upd;
  int         m_fi, m_ri, m_new;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % 256);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 256; i++) mtbl[i] = 0;
    mq.delete();
  endfunction

  task automatic drv(input logic iv, input logic ib, input logic [31:0] ipc,
                     input logic rv, input logic [31:0] rpc, input logic rt, input logic sq);
    if_valid = iv; if_br = ib; if_pc = ipc;
    rt_valid = rv; rt_pc = rpc; rt_taken = rt; squash = sq;
  endtask

  // Capture DUT outputs mid-cycle and derive expectations from the model.
  task automatic sample();
    @(negedge clk);
    got_if = bht_if_out; got_ex = bht_ex_out; got_full = snap_full;
    got_wr = pht_wr_en;  got_mm = bht_mismatch;
    m_fi  = idx_of(if_pc);
    m_ri  = idx_of(rt_pc);
    m_pop = rt_valid && (mq.size() > 0);
    exp_mm = 1'b0;
`ifdef BHT_PC_CHECK_EN
    if (m_pop && mq[0].idx != m_ri) exp_mm = 1'b1;
`endif
    m_upd    = rt_valid && !exp_mm;
    m_new    = ((mtbl[m_ri] * 2) + int'(rt_taken)) % 16;
    exp_if   = 4'((m_upd && m_ri == m_fi) ? m_new : mtbl[m_fi]);
    exp_ex   = 4'((mq.size() > 0) ? mq[0].hist : 0);
    exp_full = (mq.size() == DEPTH);
    exp_wr   = m_pop && !exp_mm;
  endtask

  task automatic commit();
    logic push;
    push = if_valid && if_br && (mq.size() < DEPTH) && !squash;
    if (m_upd) mtbl[m_ri] = m_new;
    if (m_pop) void'(mq.pop_front());
    if (squash) mq.delete();
    else if (push) mq.push_back('{m_fi, int'(exp_if)});
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] head_pc();
    return (mq.size() > 0) ? 32'(mq[0].idx * 4) : 32'h0;
  endfunction

  task automatic test_reset();
    drv(1, 1, 32'h40, 0, 32'h0, 0, 0);
    #3;
    checks++; if (bht_if_out !== 4'h0) begin errors++; $display("FAIL reset_if got %h want 0", bht_if_out); end
    checks++; if (snap_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", snap_full); end
    checks++; if (pht_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr got %b want 0", pht_wr_en); end
    checks++; if (bht_ex_out !== 4'h0) begin errors++; $display("FAIL reset_ex got %h want 0", bht_ex_out); end
    checks++; if (bht_mismatch !== 1'b0) begin errors++; $display("FAIL reset_mm got %b want 0", bht_mismatch); end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_fetch_basic();
    drv(1, 1, 32'h40, 0, 32'h0, 0, 0); sample();
    checks++; if (got_if !== 4'h0) begin errors++; $display("FAIL basic_if got %h want 0", got_if); end
    commit();
    drv(0, 0, 32'h0, 0, 32'h0, 0, 0); sample();
    checks++; if (got_full !== 1'b0) begin errors++; $display("FAIL basic_full got %b want 0", got_full); end
    commit();
  endtask

  task automatic test_bypass();
    drv(0, 0, 32'h0, 1, 32'h40, 1, 0); sample();
    checks++; if (got_wr !== 1'b1) begin errors++; $display("FAIL byp_pop1 got %b want 1", got_wr); end
    commit();
    drv(0, 0, 32'h0, 1, 32'h40, 1, 0); sample();
    checks++; if (got_wr !== 1'b0) begin errors++; $display("FAIL byp_empty_wr got %b want 0", got_wr); end
    commit();
    drv(1, 1, 32'h40, 1, 32'h40, 1, 0); sample();
    checks++; if (got_if !== 4'b0111) begin errors++; $display("FAIL byp_if got %b want 0111", got_if); end
    commit();
    drv(0, 0, 32'h40, 0, 32'h0, 0, 0); sample();
    checks++; if (got_if !== 4'b0111) begin errors++; $display("FAIL byp_tbl got %b want 0111", got_if); end
    commit();
    drv(0, 0, 32'h0, 1, 32'h40, 0, 0); sample();
    checks++; if (got_ex !== 4'b0111 || got_wr !== 1'b1) begin
      errors++; $display("FAIL byp_ex got %b/%b want 0111/1", got_ex, got_wr); end
    commit();
  endtask

  task automatic test_full();
    drv(0, 0, 32'h0, 0, 32'h0, 0, 1); sample(); commit();
    for (int i = 0; i < DEPTH; i++) begin
      drv(1, 1, 32'h40 + 32'($urandom_range(0, 7) * 4), 0, 32'h0, 0, 0); sample(); commit();
    end
    drv(1, 1, 32'h60, 0, 32'h0, 0, 0); sample();
    checks++; if (got_full !== 1'b1) begin errors++; $display("FAIL full_flag got %b want 1", got_full); end
    commit();
    drv(1, 1, 32'h64, 1, head_pc(), 1'($urandom_range(0, 1)), 0); sample();
    checks++; if (got_full !== 1'b1 || got_wr !== 1'b1) begin
      errors++; $display("FAIL full_poppush got full=%b wr=%b want 1/1", got_full, got_wr); end
    checks++; if (got_ex !== exp_ex) begin errors++; $display("FAIL full_ex got %h want %h", got_ex, exp_ex); end
    commit();
    for (int i = 0; i < DEPTH; i++) begin
      drv(0, 0, 32'h0, 1, head_pc(), 1'($urandom_range(0, 1)), 0); sample();
      if (i == 0) begin
        checks++; if (got_full !== 1'b0) begin errors++; $display("FAIL drain_full got %b want 0", got_full); end
      end
      checks++; if (got_wr !== ((i < DEPTH - 1) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL drain_wr%0d got %b want %b", i, got_wr, (i < DEPTH - 1)); end
      checks++; if (got_ex !== exp_ex) begin errors++; $display("FAIL drain_ex%0d got %h want %h", i, got_ex, exp_ex); end
      commit();
    end
  endtask

  task automatic test_snapshot();
    logic [3:0] pat;
    pat = 4'b0011;
    drv(0, 0, 32'h0, 0, 32'h0, 0, 1); sample(); commit();
    for (int i = 3; i >= 0; i--) begin
      drv(0, 0, 32'h0, 1, 32'h100, pat[i], 0); sample(); commit();
    end
    drv(1, 1, 32'h100, 0, 32'h0, 0, 0); sample();
    checks++; if (got_if !== 4'b0011) begin errors++; $display("FAIL snap_if got %b want 0011", got_if); end
    commit();
    drv(1, 1, 32'h100, 1, 32'h100, 0, 0); sample();
    checks++; if (got_ex !== 4'b0011 || got_wr !== 1'b1) begin
      errors++; $display("FAIL snap_ex got %b/%b want 0011/1", got_ex, got_wr); end
    checks++; if (got_if !== 4'b0110) begin errors++; $display("FAIL snap_byp got %b want 0110", got_if); end
    commit();
    drv(0, 0, 32'h0, 1, 32'h100, 0, 0); sample();
    checks++; if (got_ex !== 4'b0110) begin errors++; $display("FAIL snap_ex2 got %b want 0110", got_ex); end
    commit();
  endtask

  task automatic test_squash();
    drv(1, 1, 32'h200, 0, 32'h0, 0, 0); sample(); commit();
    drv(1, 1, 32'h204, 0, 32'h0, 0, 0); sample(); commit();
    drv(1, 1, 32'h208, 1, 32'h200, 1, 1); sample();
    checks++; if (got_wr !== 1'b1) begin errors++; $display("FAIL sq_wr got %b want 1", got_wr); end
    commit();
    drv(0, 0, 32'h0, 1, 32'h208, 1, 0); sample();
    checks++; if (got_wr !== 1'b0 || got_ex !== 4'h0) begin
      errors++; $display("FAIL sq_empty got wr=%b ex=%h want 0/0", got_wr, got_ex); end
    commit();
  endtask

`ifdef BHT_PC_CHECK_EN
  task automatic test_pc_check();
    int before;
    drv(1, 1, 32'h80, 0, 32'h0, 0, 0); sample(); commit();
    before = mtbl[idx_of(32'h84)];
    drv(0, 0, 32'h0, 1, 32'h84, 1, 0); sample();
    checks++; if (got_mm !== 1'b1 || got_wr !== 1'b0) begin
      errors++; $display("FAIL pc_mm got mm=%b wr=%b want 1/0", got_mm, got_wr); end
    commit();
    drv(0, 0, 32'h84, 0, 32'h0, 0, 0); sample();
    checks++; if (got_if !== 4'(before)) begin errors++; $display("FAIL pc_tbl got %h want %h", got_if, 4'(before)); end
    commit();
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drv(1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 9) < 6),
          32'h40 + 32'($urandom_range(0, 5) * 4),
          1'($urandom_range(0, 1)), 32'h40 + 32'($urandom_range(0, 5) * 4),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 24) == 0));
      sample();
      checks++; if (got_if !== exp_if) begin errors++; $display("FAIL rnd%0d if got %h want %h", n, got_if, exp_if); end
      checks++; if (got_ex !== exp_ex) begin errors++; $display("FAIL rnd%0d ex got %h want %h", n, got_ex, exp_ex); end
      checks++; if (got_full !== exp_full) begin errors++; $display("FAIL rnd%0d full got %b want %b", n, got_full, exp_full); end
      checks++; if (got_wr !== exp_wr) begin errors++; $display("FAIL rnd%0d wr got %b want %b", n, got_wr, exp_wr); end
      checks++; if (got_mm !== exp_mm) begin errors++; $display("FAIL rnd%0d mm got %b want %b", n, got_mm, exp_mm); end
      commit();
    end
  endtask

  task automatic test_mid_reset();
    drv(0, 0, 32'h0, 1, 32'h40, 1, 0); sample(); commit();
    drv(1, 1, 32'h40, 0, 32'h0, 0, 0); sample(); commit();
    drv(0, 0, 32'h40, 0, 32'h0, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bht_if_out !== 4'h0 || bht_ex_out !== 4'h0) begin
      errors++; $display("FAIL mid_reset_hist got if=%h ex=%h want 0/0", bht_if_out, bht_ex_out); end
    checks++; if (snap_full !== 1'b0 || pht_wr_en !== 1'b0 || bht_mismatch !== 1'b0) begin
      errors++; $display("FAIL mid_reset_ctl got full=%b wr=%b mm=%b want 0", snap_full, pht_wr_en, bht_mismatch); end
    model_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    drv(0, 0, 32'h0, 1, 32'h40, 0, 0); sample();
    checks++; if (got_wr !== 1'b0 || got_ex !== 4'h0) begin
      errors++; $display("FAIL post_reset got wr=%b ex=%h want 0/0", got_wr, got_ex); end
    commit();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fetch_basic();
    test_bypass();
    test_full();
    test_snapshot();
    test_squash();
`ifdef BHT_PC_CHECK_EN
    test_pc_check();
`endif
    test_random();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
